// File: rtl/translater_nch_pkg.sv
// Shared defaults and helpers for the multi-lane translater.
// CNT_W is always derived from HOLD_MAX through clog2.
package translater_nch_pkg;

  localparam int CHANNELS_DEF = 32'd4;
  localparam int WIDTH_DEF    = 32'd8;
  localparam int HOLD_MAX_DEF = 32'd15;

  function automatic int clog2(input int value);
    int result;
    result = 32'd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) result = i + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/translater_nch_if.sv
// Lane bus between the VC arbiter side and the QoS buffer side.
// The master drives the controls; the slave (the translater) returns the lane outputs.
interface translater_nch_if
  import translater_nch_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) ();

  localparam int CNT_W = clog2(HOLD_MAX + 32'd1);

  logic                      ENB;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       selector;
  logic [CHANNELS-1:0]       bypass_mask;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       stale;
  logic [CHANNELS*CNT_W-1:0] hold_count;

  modport master (
    output ENB, in_data, in_valid, selector, bypass_mask,
    input  out_data, out_valid, stale, hold_count
  );

  modport slave (
    input  ENB, in_data, in_valid, selector, bypass_mask,
    output out_data, out_valid, stale, hold_count
  );

endinterface

// File: rtl/translater_nch_lane.sv
// One translater lane: data register, capture pulse, saturating hold-age counter
// and a registered stale flag.
module translater_nch_lane
  import translater_nch_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int HOLD_MAX = HOLD_MAX_DEF,
  localparam int CNT_W    = clog2(HOLD_MAX + 32'd1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pass,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             stale,
  output logic [CNT_W-1:0] hold_count
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(HOLD_MAX);

  logic             cap;
  logic [CNT_W-1:0] count_next;

  // Capture decision and next hold age; the age saturates instead of wrapping.
  always_comb begin
    cap        = pass & in_valid;
    count_next = hold_count;
    if (cap) begin
      count_next = {CNT_W{1'b0}};
    end else if (hold_count == CNT_SAT) begin
      count_next = CNT_SAT;
    end else begin
      count_next = hold_count + CNT_W'(1);
    end
  end

  // Lane state; stale is registered from the next age so it never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data   <= {WIDTH{1'b0}};
      out_valid  <= 1'b0;
      hold_count <= {CNT_W{1'b0}};
      stale      <= 1'b0;
    end else begin
      if (cap) out_data <= in_data;
      out_valid  <= cap;
      hold_count <= count_next;
      stale      <= (count_next == CNT_SAT);
    end
  end

endmodule

// File: rtl/translater_nch.sv
// Multi-lane translater: per-lane pass selection (selector when enabled,
// bypass mask otherwise) feeding independent lane instances.
module translater_nch
  import translater_nch_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  translater_nch_if.slave   bus
);

  localparam int CNT_W = clog2(HOLD_MAX + 32'd1);

  logic [CHANNELS-1:0] pass;
  logic [WIDTH-1:0]    lane_data  [CHANNELS];
  logic                lane_valid [CHANNELS];
  logic                lane_stale [CHANNELS];
  logic [CNT_W-1:0]    lane_count [CHANNELS];

  // Enabled lanes capture on selector=0; disabled lanes follow the bypass mask.
  always_comb begin
    pass = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.ENB) begin
        pass[i] = ~bus.selector[i];
      end else begin
        pass[i] = bus.bypass_mask[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    translater_nch_lane #(
      .WIDTH    (WIDTH),
      .HOLD_MAX (HOLD_MAX)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .pass       (pass[g]),
      .in_valid   (bus.in_valid[g]),
      .in_data    (bus.in_data[g*WIDTH +: WIDTH]),
      .out_data   (lane_data[g]),
      .out_valid  (lane_valid[g]),
      .stale      (lane_stale[g]),
      .hold_count (lane_count[g])
    );
  end

  // Pack lane registers onto the bus.
  always_comb begin
    bus.out_data   = {(CHANNELS*WIDTH){1'b0}};
    bus.out_valid  = {CHANNELS{1'b0}};
    bus.stale      = {CHANNELS{1'b0}};
    bus.hold_count = {(CHANNELS*CNT_W){1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      bus.out_data[i*WIDTH +: WIDTH]   = lane_data[i];
      bus.out_valid[i]                 = lane_valid[i];
      bus.stale[i]                     = lane_stale[i];
      bus.hold_count[i*CNT_W +: CNT_W] = lane_count[i];
    end
  end

endmodule
